// File: rtl/ace_ccu_snoop_issue_pkg.sv
// Shared types for the CCU snoop issue stage: request record, ACSNOOP codes, FSM states.
package ace_ccu_pkg;

  // Widest request address carried through the input buffer.
  localparam int unsigned AceAddrWidth = 64;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t ReadShared   = 4'b0001;
  localparam acsnoop_t ReadUnique   = 4'b0111;
  localparam acsnoop_t CleanInvalid = 4'b1001;
  localparam acsnoop_t MakeInvalid  = 4'b1101;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    acsnoop_t                snoop;
  } snoop_req_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE
  } issue_state_e;

endpackage

// File: rtl/ace_ccu_snoop_issue_if.sv
// Bundle of request, conflict-manager, AC and completion signals of the snoop issue stage.
interface ace_ccu_snoop_issue_if #(
  parameter int unsigned AxiAddrWidth  = 64,
  parameter int unsigned CmAddrWidth   = 58,
  parameter int unsigned MaxSnoopTrans = 4
);
  localparam int unsigned CntW = $clog2(MaxSnoopTrans + 1);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AxiAddrWidth-1:0] req_addr_i;
  logic [3:0]              req_snoop_i;
  logic                    cm_snoop_valid_o;
  logic                    cm_snoop_ready_o;
  logic [CmAddrWidth-1:0]  cm_snoop_addr_o;
  logic                    cm_snoop_stall_i;
  logic                    ac_valid_o;
  logic                    ac_ready_i;
  logic [AxiAddrWidth-1:0] ac_addr_o;
  logic [3:0]              ac_snoop_o;
  logic                    cr_done_i;
  logic [CntW-1:0]         outstanding_o;
  logic                    err_o;

  // Issue-stage side.
  modport slave (
    input  req_valid_i, req_addr_i, req_snoop_i, cm_snoop_stall_i, ac_ready_i, cr_done_i,
    output req_ready_o, cm_snoop_valid_o, cm_snoop_ready_o, cm_snoop_addr_o,
           ac_valid_o, ac_addr_o, ac_snoop_o, outstanding_o, err_o
  );

  // Environment side: request source, conflict manager, AC sink, completion source.
  modport master (
    output req_valid_i, req_addr_i, req_snoop_i, cm_snoop_stall_i, ac_ready_i, cr_done_i,
    input  req_ready_o, cm_snoop_valid_o, cm_snoop_ready_o, cm_snoop_addr_o,
           ac_valid_o, ac_addr_o, ac_snoop_o, outstanding_o, err_o
  );
endinterface

// File: rtl/ace_ccu_sync_fifo.sv
// Registered FIFO (no fall-through), synchronous active-high reset.
// Push at full is accepted only together with a pop; pop at empty is ignored.
module ace_ccu_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  T                mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= data_i;
  end
endmodule

// File: rtl/ace_ccu_snoop_issue.sv
// Snoop issue stage: buffers snoop requests, looks each line up in the conflict
// manager, reserves on a clear lookup and drives the AC channel. In-flight snoops
// are bounded by a completion-credit counter.
module ace_ccu_snoop_issue
  import ace_ccu_pkg::*;
#(
  parameter int unsigned AxiAddrWidth  = 64,
  parameter int unsigned LineOffset    = 6,
  parameter int unsigned CmAddrWidth   = 58,
  parameter int unsigned MaxSnoopTrans = 4,
  parameter int unsigned FifoDepth     = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  ace_ccu_snoop_issue_if.slave bus
);
  localparam int unsigned          CntW     = $clog2(MaxSnoopTrans + 1);
  localparam logic [CntW-1:0]      MaxCnt   = CntW'(MaxSnoopTrans);
  localparam logic [AxiAddrWidth-1:0] LineMask =
    ~((AxiAddrWidth'(1) << LineOffset) - AxiAddrWidth'(1));

  issue_state_e            state_q, state_d;
  snoop_req_t              push_req, head_req;
  logic                    fifo_full, fifo_empty, push, reserve, cm_valid, credit;
  logic [AxiAddrWidth-1:0] head_addr;
  logic [AxiAddrWidth-1:0] ac_addr_q;
  acsnoop_t                ac_snoop_q;
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;

  assign push_req.addr  = AceAddrWidth'(bus.req_addr_i);
  assign push_req.snoop = bus.req_snoop_i;
  assign head_addr      = AxiAddrWidth'(head_req.addr);

  // Nothing is accepted while reset is asserted.
  assign bus.req_ready_o = !fifo_full && !rst_i;
  assign push            = bus.req_valid_i && bus.req_ready_o;
  assign credit          = (cnt_q < MaxCnt);

  ace_ccu_sync_fifo #(
    .DEPTH (FifoDepth),
    .T     (snoop_req_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (reserve),
    .data_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and lookup outputs. Reserve depends only on stall and credit,
  // never on ac_ready_i, so AC backpressure has no comb path to the CM.
  always_comb begin
    state_d  = state_q;
    cm_valid = 1'b0;
    reserve  = 1'b0;
    unique case (state_q)
      IDLE:  if (!fifo_empty || push) state_d = CHECK;
      CHECK: begin
        cm_valid = 1'b1;
        if (!bus.cm_snoop_stall_i && credit) begin
          reserve = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: if (bus.ac_ready_i) state_d = (!fifo_empty || push) ? CHECK : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.cm_snoop_valid_o = cm_valid;
  assign bus.cm_snoop_ready_o = reserve;
  assign bus.cm_snoop_addr_o  = cm_valid ? CmAddrWidth'(head_addr >> LineOffset) : '0;

  // AC payload captured at reservation, held stable through ISSUE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ac_addr_q  <= '0;
      ac_snoop_q <= '0;
    end else if (reserve) begin
      ac_addr_q  <= head_addr & LineMask;
      ac_snoop_q <= head_req.snoop;
    end
  end

  assign bus.ac_valid_o = (state_q == ISSUE);
  assign bus.ac_addr_o  = ac_addr_q;
  assign bus.ac_snoop_o = ac_snoop_q;

  // Completion credits; a completion with nothing outstanding flags a sticky error.
  // Overflow is impossible because reserve requires free credit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case ({reserve, bus.cr_done_i})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
          else             err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.outstanding_o = cnt_q;
  assign bus.err_o         = err_q;
endmodule
